// File: rtl/sha2_padder_pkg.sv
// sha2_padder_pkg: shared types, codec constants, block geometry and helpers for the SHA-2 padder
package sha2_padder_pkg;
  typedef enum logic [1:0] {IDLE, ACCEPT, PAD, SEND} st_e;
  typedef enum logic [1:0] {SHA224, SHA256, SHA384, SHA512} sha_e;
  localparam int CODEC_POS = 0;
  localparam int CODEC_W = 16;
  localparam logic [CODEC_W-1:0] CODEC_SHA2_224 = 16'h1013;
  localparam logic [CODEC_W-1:0] CODEC_SHA2_256 = 16'h0012;
  localparam logic [CODEC_W-1:0] CODEC_SHA2_384 = 16'h0020;
  localparam logic [CODEC_W-1:0] CODEC_SHA2_512 = 16'h0013;
  localparam int BLOCK512_BEATS = 1;
  localparam int BLOCK1024_BEATS = 2;
  localparam int L_512 = 1;
  localparam int L_1024 = 2;
  localparam logic [63:0] MARKER_WORD = 64'h8000_0000_0000_0000;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/sha2_padder_sha_type_decoder.sv
// sha_type_decoder: maps a multiformats codec to a SHA-2 variant, unknown codecs fall back to SHA-224
module sha_type_decoder
  import sha2_padder_pkg::*;
(
  input  logic [CODEC_W-1:0] codec,
  output sha_e               sha_type
);
  always_comb
    sha_type = codec == CODEC_SHA2_224 ? SHA224 :
               codec == CODEC_SHA2_256 ? SHA256 :
               codec == CODEC_SHA2_384 ? SHA384 :
               codec == CODEC_SHA2_512 ? SHA512 : SHA224;
endmodule

// File: rtl/sha2_padder.sv
// sha2_padder: SHA-2 message padder, 64-bit AXI-Stream message in, 512-bit padded beats out
module sha2_padder
  import sha2_padder_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128
) (
  input  logic                           axis_aclk,
  input  logic                           axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [7:0]                     s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);
  st_e st_q, st_d;
  logic [7:0][63:0] buf_q, buf_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [2:0] w_q, w_d;
  logic [60:0] nbytes_q, nbytes_d;
  logic half_q, half_d, big_q, big_d, pend_q, pend_d, mdone_q, mdone_d;
  logic lok_q, lok_d, last_q, last_d, fin_q, fin_d;
  logic s_rdy_q, s_rdy_d, m_vld_q, m_vld_d, m_last_q, m_last_d;
  sha_e dec_type;
  logic dec_big, big_now, elig, s_hs;
  logic [2:0] lim;
  logic [3:0] kcnt;
  logic [63:0] kmask, in_word;
  sha_type_decoder u_dec (
    .codec    (s_axis_tuser[CODEC_POS +: CODEC_W]),
    .sha_type (dec_type)
  );
  always_comb
    for (int i = 0; i < 8; i++) kmask[8*i +: 8] = {8{s_axis_tkeep[i]}};
  always_comb begin
    dec_big = dec_type == SHA384 || dec_type == SHA512;
    big_now = st_q == IDLE ? dec_big : big_q;
    lim = big_now ? 3'(7 - L_1024) : 3'(7 - L_512);
    elig = int'(half_q) == (big_now ? BLOCK1024_BEATS : BLOCK512_BEATS) - 1;
    s_hs = s_axis_tvalid && s_rdy_q;
    kcnt = popcount8(s_axis_tkeep);
    in_word = (s_axis_tdata & kmask) | (s_axis_tlast ? MARKER_WORD >> {kcnt, 3'b000} : '0);
    st_d = st_q;
    buf_d = buf_q;
    tuser_d = tuser_q;
    w_d = w_q;
    nbytes_d = nbytes_q;
    half_d = half_q;
    big_d = big_q;
    pend_d = pend_q;
    mdone_d = mdone_q;
    lok_d = lok_q;
    last_d = last_q;
    if (s_hs) begin
      tuser_d = st_q == IDLE ? s_axis_tuser : tuser_q;
      big_d = big_now;
      buf_d[~w_q] = in_word;
      nbytes_d = nbytes_q + 61'(kcnt);
      w_d = w_q + 3'd1;
      pend_d = s_axis_tlast ? kcnt[3] : pend_q;
      mdone_d = s_axis_tlast ? !kcnt[3] : mdone_q;
      lok_d = s_axis_tlast ? !kcnt[3] && w_q <= lim : lok_q;
      last_d = last_q || s_axis_tlast;
      st_d = w_q == 3'd7 ? SEND : s_axis_tlast ? PAD : ACCEPT;
    end else if (st_q == PAD) begin
      buf_d[~w_q] = pend_q ? MARKER_WORD : (w_q == 3'd7 && elig && lok_q) ? {nbytes_q, 3'b000} : '0;
      pend_d = 1'b0;
      mdone_d = mdone_q || pend_q;
      lok_d = lok_q || (pend_q && w_q <= lim);
      w_d = w_q + 3'd1;
      st_d = w_q == 3'd7 ? SEND : PAD;
    end else if (st_q == SEND && m_axis_tready) begin
      w_d = '0;
      half_d = big_q && !half_q && !fin_q;
      mdone_d = mdone_q && !fin_q;
      lok_d = mdone_q && !fin_q;
      last_d = last_q && !fin_q;
      nbytes_d = fin_q ? '0 : nbytes_q;
      st_d = fin_q ? IDLE : last_q ? PAD : ACCEPT;
    end
    fin_d = (st_d == SEND && st_q != SEND) ? elig && lok_d : fin_q;
    s_rdy_d = st_d == IDLE || st_d == ACCEPT;
    m_vld_d = st_d == SEND;
    m_last_d = st_d == SEND && fin_d;
  end
  always_ff @(posedge axis_aclk)
    if (axis_reset) begin
      st_q <= IDLE;
      buf_q <= '0;
      tuser_q <= '0;
      w_q <= '0;
      nbytes_q <= '0;
      half_q <= 1'b0;
      big_q <= 1'b0;
      pend_q <= 1'b0;
      mdone_q <= 1'b0;
      lok_q <= 1'b0;
      last_q <= 1'b0;
      fin_q <= 1'b0;
      s_rdy_q <= 1'b0;
      m_vld_q <= 1'b0;
      m_last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      buf_q <= buf_d;
      tuser_q <= tuser_d;
      w_q <= w_d;
      nbytes_q <= nbytes_d;
      half_q <= half_d;
      big_q <= big_d;
      pend_q <= pend_d;
      mdone_q <= mdone_d;
      lok_q <= lok_d;
      last_q <= last_d;
      fin_q <= fin_d;
      s_rdy_q <= s_rdy_d;
      m_vld_q <= m_vld_d;
      m_last_q <= m_last_d;
    end
  assign s_axis_tready = s_rdy_q;
  assign m_axis_tdata = buf_q;
  assign m_axis_tuser = tuser_q;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tlast = m_last_q;
endmodule

// File: tb/tb_sha2_padder.sv
// tb_sha2_padder: directed self-checking bench for sha2_padder
module tb_sha2_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic [127:0] s_tuser = '0;
  logic s_tvalid = 1'b0;
  logic s_tready;
  logic s_tlast = 1'b0;
  logic [511:0] m_tdata;
  logic [127:0] m_tuser;
  logic m_tvalid;
  logic m_tready = 1'b1;
  logic m_tlast;
  int vectors = 0;
  int miscompares = 0;
  logic [511:0] got_d[$];
  logic got_l[$];
  logic [127:0] got_u[$];
  localparam logic [511:0] A256 = {64'h6162_6380_0000_0000, 384'h0, 64'h18};
  sha2_padder dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && m_tvalid && m_tready) begin
      got_d.push_back(m_tdata);
      got_l.push_back(m_tlast);
      got_u.push_back(m_tuser);
    end
  function automatic logic [7:0] mb(input int p);
    return 8'(p * 5 + 17);
  endfunction
  function automatic logic [127:0] usr(input int tag, input logic [15:0] codec);
    return {112'(tag) ^ 112'hC0FFEE, codec};
  endfunction
  function automatic logic [63:0] word_of(input int n, input int i);
    logic [63:0] d = '0;
    for (int j = 0; j < 8; j++) if (i * 8 + j < n) d[63-8*j -: 8] = mb(i * 8 + j);
    return d;
  endfunction
  function automatic logic [7:0] keep_of(input int n, input int i);
    logic [7:0] k = '0;
    for (int j = 0; j < 8; j++) if (i * 8 + j < n) k[7-j] = 1'b1;
    return k;
  endfunction
  function automatic int total_bytes(input int n, input bit big);
    int bs = big ? 128 : 64;
    int lb = big ? 16 : 8;
    return ((n + 1 + lb + bs - 1) / bs) * bs;
  endfunction
  function automatic logic [511:0] exp_beat(input int n, input bit big, input int k);
    int lb = big ? 16 : 8;
    int tot = total_bytes(n, big);
    logic [127:0] len = 128'(n) << 3;
    logic [511:0] r = '0;
    for (int j = 0; j < 64; j++) begin
      int p;
      logic [7:0] b;
      p = k * 64 + j;
      b = p < n ? mb(p) : p == n ? 8'h80 : p >= tot - lb ? len[8*(tot-1-p) +: 8] : 8'h00;
      r[511-8*j -: 8] = b;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  task automatic clear();
    got_d.delete();
    got_l.delete();
    got_u.delete();
  endtask
  task automatic finish_put();
    int c = 0;
    @(negedge clk);
    while (!s_tready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("s_tready_wait", 512'(s_tready), 512'(1));
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [127:0] u);
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1'b1;
    finish_put();
  endtask
  task automatic send_msg(input int n, input logic [127:0] u, input bit tail);
    int words = (n + 7) / 8;
    for (int i = 0; i < words; i++)
      put(word_of(n, i), keep_of(n, i), !tail && i == words - 1, i == 0 ? u : ~u);
    if (tail || words == 0) put(64'h0, 8'h00, 1'b1, words == 0 ? u : ~u);
  endtask
  task automatic lat_chk(input int e);
    int n = 1;
    while (!m_tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 512'(n), 512'(e));
  endtask
  task automatic wait_beats(input int n);
    int c = 0;
    while (got_d.size() < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    repeat (12) @(posedge clk);
    #1;
    chk("beat_count", 512'(got_d.size()), 512'(n));
  endtask
  task automatic check_msg(input int n, input bit big, input logic [127:0] u);
    int nb = total_bytes(n, big) / 64;
    wait_beats(nb);
    for (int i = 0; i < nb; i++) begin
      chk("msg_data", got_d[i], exp_beat(n, big, i));
      chk("msg_tlast", 512'(got_l[i]), 512'(i == nb - 1));
      chk("msg_tuser", 512'(got_u[i]), 512'(u));
    end
  endtask
  initial begin
    logic [127:0] u;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 512'(s_tready), 512'(0));
    chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    chk("rst_m_tlast", 512'(m_tlast), 512'(0));
    chk("rst_m_tdata", m_tdata, 512'(0));
    chk("rst_m_tuser", 512'(m_tuser), 512'(0));
    rst = 1'b0;
    clear();
    u = usr(1, 16'h0012);
    put(64'h6162_6300_0000_0000, 8'hE0, 1'b1, u);
    lat_chk(8);
    wait_beats(1);
    chk("abc256_data", got_d[0], A256);
    chk("abc256_tlast", 512'(got_l[0]), 512'(1));
    chk("abc256_tuser", 512'(got_u[0]), 512'(u));
    clear();
    u = usr(55, 16'h0012);
    send_msg(55, u, 1'b0);
    lat_chk(2);
    check_msg(55, 1'b0, u);
    chk("len55", 512'(got_d[0][63:0]), 512'(64'h1B8));
    chk("marker55", 512'(got_d[0][71:64]), 512'(8'h80));
    clear();
    u = usr(56, 16'h0012);
    send_msg(56, u, 1'b0);
    check_msg(56, 1'b0, u);
    chk("b2_56", got_d[1], {448'h0, 64'h1C0});
    clear();
    u = usr(64, 16'h0012);
    send_msg(64, u, 1'b0);
    lat_chk(1);
    check_msg(64, 1'b0, u);
    chk("b2_64", got_d[1], {8'h80, 440'h0, 64'h200});
    clear();
    u = usr(3, 16'h0013);
    put(64'h6162_6300_0000_0000, 8'hE0, 1'b1, u);
    wait_beats(2);
    chk("abc512_L", got_d[0], {32'h6162_6380, 480'h0});
    chk("abc512_R", got_d[1], {384'h0, 128'h18});
    chk("abc512_tlast_L", 512'(got_l[0]), 512'(0));
    chk("abc512_tlast_R", 512'(got_l[1]), 512'(1));
    clear();
    u = usr(112, 16'h0013);
    send_msg(112, u, 1'b0);
    check_msg(112, 1'b1, u);
    chk("len112", 512'(got_d[3][127:0]), 512'(128'h380));
    clear();
    u = usr(0, 16'h0012);
    send_msg(0, u, 1'b0);
    check_msg(0, 1'b0, u);
    chk("empty_data", got_d[0], {8'h80, 504'h0});
    clear();
    u = usr(16, 16'h0020);
    send_msg(16, u, 1'b1);
    check_msg(16, 1'b1, u);
    clear();
    u = usr(5, 16'hFFFF);
    put(64'h6162_6300_0000_0000, 8'hE0, 1'b1, u);
    wait_beats(1);
    chk("unknown_codec", got_d[0], A256);
    clear();
    m_tready = 1'b0;
    u = usr(72, 16'h0012);
    for (int i = 0; i < 8; i++) put(word_of(72, i), keep_of(72, i), 1'b0, i == 0 ? u : ~u);
    s_tdata = word_of(72, 8);
    s_tkeep = keep_of(72, 8);
    s_tlast = 1'b1;
    s_tuser = ~u;
    s_tvalid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_data", m_tdata, exp_beat(72, 1'b0, 0));
      chk("bp_tuser", 512'(m_tuser), 512'(u));
      chk("bp_tlast", 512'(m_tlast), 512'(0));
      chk("bp_tvalid", 512'(m_tvalid), 512'(1));
      chk("bp_s_tready", 512'(s_tready), 512'(0));
    end
    m_tready = 1'b1;
    finish_put();
    check_msg(72, 1'b0, u);
    clear();
    u = usr(9, 16'h0013);
    for (int i = 0; i < 3; i++) put(word_of(64, i), keep_of(64, i), 1'b0, u);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_tuser", 512'(m_tuser), 512'(0));
    chk("midrst_s_tready", 512'(s_tready), 512'(0));
    rst = 1'b0;
    clear();
    u = usr(77, 16'h0012);
    put(64'h6162_6300_0000_0000, 8'hE0, 1'b1, u);
    wait_beats(1);
    chk("postrst_data", got_d[0], A256);
    chk("postrst_tuser", 512'(got_u[0]), 512'(u));
    chk("postrst_tlast", 512'(got_l[0]), 512'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
